// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS fetch path: fixed vectors, next-PC select
// encoding and the PC sequencer state encoding.
package cpu_pkg;

  localparam logic [31:0] CPU_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] CPU_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] CPU_EXC_VEC   = 32'h8000_0008;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_J   = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-fetch candidate: PC+4, branch, jump or jr.
// User-mode jr targets have bit 31 cleared so they cannot reach kernel space.
module pc_next_mux
  import cpu_pkg::*;
(
  input  logic [3:0]  pc_hi,
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic [25:0] jump_idx,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic kernel_s;
  assign kernel_s = pc_hi[3];

  // Candidate select; only kernel code may keep bit 31 on a jr.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SEQ: next_pc = pc_plus4;
      PC_BR: begin
        if (branch_taken) begin
          next_pc = pc_plus4 + branch_off;
        end else begin
          next_pc = pc_plus4;
        end
      end
      PC_J:    next_pc = {pc_hi, jump_idx, 2'b00};
      PC_JR:   next_pc = {jr_target[31] & kernel_s, jr_target[30:0]};
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with vector entry for exceptions and interrupts.
// Optional ROM bounds check enabled by defining PC_SEQ_BOUNDS_CHECK_EN.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ROM_WORDS = 128,
  parameter logic [31:0] RESET_VEC = CPU_RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = CPU_IRQ_VEC,
  parameter logic [31:0] EXC_VEC   = CPU_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic [25:0] jump_idx,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        kernel,
  output logic        k0_we,
  output logic [31:0] epc,
  output logic        irq_ack
);

`ifdef PC_SEQ_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [31:0] ROM_WORDS_C = 32'(ROM_WORDS);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        k0_we_q, k0_we_d;
  logic        irq_ack_q, irq_ack_d;
  logic        irq_pend_q, irq_pend_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] cand_s;
  logic        pend_s;
  logic        oob_s;

  assign pc_plus4_s = pc_q + 32'd4;
  // A request seen this cycle counts as pending right away.
  assign pend_s     = irq_pend_q | irq;
  assign oob_s      = BOUNDS_EN && ({3'b000, cand_s[30:2]} >= ROM_WORDS_C);

  pc_next_mux u_next_mux (
    .pc_hi        (pc_q[31:28]),
    .pc_plus4     (pc_plus4_s),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump_idx     (jump_idx),
    .jr_target    (jr_target),
    .next_pc      (cand_s)
  );

  // Next-state logic: exception beats interrupt beats bounds check beats the candidate.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    k0_we_d    = 1'b0;
    irq_ack_d  = 1'b0;
    irq_pend_d = pend_s;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (stall) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
          if (exc) begin
            pc_d    = EXC_VEC;
            epc_d   = pc_plus4_s;
            k0_we_d = 1'b1;
          end else if (pend_s && !pc_q[31]) begin
            pc_d       = IRQ_VEC;
            epc_d      = pc_q;
            k0_we_d    = 1'b1;
            irq_ack_d  = 1'b1;
            irq_pend_d = 1'b0;
          end else if (oob_s) begin
            pc_d    = EXC_VEC;
            epc_d   = cand_s;
            k0_we_d = 1'b1;
          end else begin
            pc_d = cand_s;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      epc_q      <= 32'h0000_0000;
      k0_we_q    <= 1'b0;
      irq_ack_q  <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      k0_we_q    <= k0_we_d;
      irq_ack_q  <= irq_ack_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_s;
  assign kernel   = pc_q[31];
  assign k0_we    = k0_we_q;
  assign epc      = epc_q;
  assign irq_ack  = irq_ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_sequencer;

  localparam logic [31:0] RST_V = 32'h8000_0000;
  localparam logic [31:0] IRQ_V = 32'h8000_0004;
  localparam logic [31:0] EXC_V = 32'h8000_0008;
  localparam int unsigned WORDS = 128;
`ifdef PC_SEQ_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        k0;
    logic        ack;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_off = 32'd0;
  logic [25:0] jump_idx = 26'd0;
  logic [31:0] jr_target = 32'd0;
  logic        irq = 1'b0;
  logic        exc = 1'b0;
  logic [31:0] pc, pc_plus4, epc;
  logic        kernel, k0_we, irq_ack;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc, m_epc;
  bit          m_pend, m_boot;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_taken(branch_taken), .branch_off(branch_off), .jump_idx(jump_idx),
    .jr_target(jr_target), .irq(irq), .exc(exc), .pc(pc), .pc_plus4(pc_plus4),
    .kernel(kernel), .k0_we(k0_we), .epc(epc), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_V; m_epc = 32'd0; m_pend = 1'b0; m_boot = 1'b1;
  endtask

  // One cycle: drive inputs, advance the model, push what the DUT must show after the edge.
  task automatic apply(input logic st, input logic [1:0] src, input logic bt,
                       input logic [31:0] boff, input logic [25:0] ji,
                       input logic [31:0] jrt, input logic iq, input logic ex);
    exp_t e;
    logic [31:0] tgt, seq;
    bit pend, kern;
    stall = st; pc_src = src; branch_taken = bt; branch_off = boff;
    jump_idx = ji; jr_target = jrt; irq = iq; exc = ex;
    pend = m_pend || iq;
    kern = m_pc[31];
    seq = m_pc + 32'd4;
    e.k0 = 1'b0; e.ack = 1'b0;
    if (src == 2'd1) tgt = bt ? seq + boff : seq;
    else if (src == 2'd2) tgt = {m_pc[31:28], ji, 2'b00};
    else if (src == 2'd3) tgt = kern ? jrt : (jrt & 32'h7FFF_FFFF);
    else tgt = seq;
    if (m_boot || st) begin
      m_boot = 1'b0;
      m_pend = pend;
    end else if (ex) begin
      m_epc = seq; m_pc = EXC_V; e.k0 = 1'b1; m_pend = pend;
    end else if (pend && !kern) begin
      m_epc = m_pc; m_pc = IRQ_V; e.k0 = 1'b1; e.ack = 1'b1; m_pend = 1'b0;
    end else if (BOUNDS && ((tgt % 32'h8000_0000) / 32'd4 >= WORDS)) begin
      m_epc = tgt; m_pc = EXC_V; e.k0 = 1'b1; m_pend = pend;
    end else begin
      m_pc = tgt; m_pend = pend;
    end
    e.pc = m_pc; e.epc = m_epc;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic nop();
    apply(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic jr(input logic [31:0] t);
    apply(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, t, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc, RST_V);
    chk("rst_pc_plus4", pc_plus4, RST_V + 32'd4);
    chk("rst_kernel", {31'd0, kernel}, 32'd1);
    chk("rst_epc", epc, 32'd0);
    chk("rst_k0_we", {31'd0, k0_we}, 32'd0);
    chk("rst_irq_ack", {31'd0, irq_ack}, 32'd0);
  endtask

  // Monitor: compare the registered outputs against the oldest expectation.
  always @(negedge clk) begin
    if (reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      chk("kernel", {31'd0, kernel}, {31'd0, e.pc[31]});
      chk("epc", epc, e.epc);
      chk("k0_we", {31'd0, k0_we}, {31'd0, e.k0});
      chk("irq_ack", {31'd0, irq_ack}, {31'd0, e.ack});
    end
  end

  initial begin
    #23;
    chk_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    chk("boot_pc", pc, RST_V);

    // Boot cycle holds, then jump with index 3
    nop();
    apply(1'b0, 2'd2, 1'b0, 32'd0, 26'd3, 32'd0, 1'b0, 1'b0);
    chk("jump_idx3", pc, 32'h8000_000C);
    // Kernel jr to user space
    jr(32'h0000_0100);
    chk("kjr_user", {31'd0, kernel}, 32'd0);
    for (int i = 0; i < 9; i++) nop();
    // irq at 0x124, then a second irq while in kernel
    apply(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    chk("irq_entry", pc, IRQ_V);
    apply(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    nop(); nop();
    jr(32'h0000_0124);
    nop();
    // Simultaneous exc and irq at 0x50
    jr(32'h0000_0050);
    apply(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b1);
    chk("exc_entry", pc, EXC_V);
    chk("exc_epc", epc, 32'h0000_0054);
    nop();
    jr(32'h0000_0054);
    nop();
    // Stall for three cycles with irq held
    jr(32'h0000_0020);
    for (int i = 0; i < 3; i++) apply(1'b1, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b1);
    apply(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    // User jr cannot enter kernel
    jr(32'h0000_0100);
    jr(32'h8000_0040);
    chk("ujr_mask", pc, 32'h0000_0040);
    // Branches taken/not taken and a jump past the ROM
    apply(1'b0, 2'd1, 1'b1, 32'hFFFF_FFF8, 26'd0, 32'd0, 1'b0, 1'b0);
    apply(1'b0, 2'd1, 1'b0, 32'h0000_0040, 26'd0, 32'd0, 1'b0, 1'b0);
    apply(1'b0, 2'd1, 1'b1, 32'h0000_0040, 26'd0, 32'd0, 1'b0, 1'b0);
    apply(1'b0, 2'd2, 1'b0, 32'd0, 26'h80, 32'd0, 1'b0, 1'b0);
    nop();

    // Asynchronous reset in mid-cycle
    @(negedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    #2;
    chk_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] jt;
      jt = ($urandom_range(0, 1) != 0 ? 32'h8000_0000 : 32'h0) | (32'($urandom_range(0, 255)) << 2);
      apply($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
            (32'($urandom_range(0, 64)) << 2) - 32'd128, 26'($urandom_range(0, 255)), jt,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and vector sequencer for the single-cycle MIPS core, driving the word-aligned address input of the instruction ROM. It holds the PC, selects the next fetch address (sequential, branch, jump, jump-register), and redirects fetch to the fixed reset, interrupt, and exception vectors. It also tracks kernel mode through PC[31] and produces the return address the datapath writes into $k0.

## Interface
- `ROM_WORDS`, default 128: instruction ROM depth in words; used only by the bounds check.
- `RESET_VEC`, default 32'h8000_0000: PC loaded on reset.
- `IRQ_VEC`, default 32'h8000_0004: interrupt entry.
- `EXC_VEC`, default 32'h8000_0008: exception entry.

Ports:
- `clk`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-low.
- `stall`  in  1  hold PC; suppresses all updates, including vector entry.
- `pc_src`  in  2  next-PC select: 0 = PC+4, 1 = branch, 2 = jump, 3 = jr.
- `branch_taken`  in  1  qualifies `pc_src`=1; if low, behaves as PC+4.
- `branch_off`  in  32  sign-extended word offset, already shifted left by 2.
- `jump_idx`  in  26  J/JAL instruction index.
- `jr_target`  in  32  rs register value.
- `irq`  in  1  level interrupt request from the timer/peripheral block.
- `exc`  in  1  undefined-instruction pulse from the decoder for the current PC.
- `pc`  out  32  current fetch address to the ROM.
- `pc_plus4`  out  32  `pc`+4, used for the JAL link.
- `kernel`  out  1  equals `pc[31]`.
- `k0_we`  out  1  one-cycle strobe: write `epc` to $k0.
- `epc`  out  32  return address captured at vector entry.
- `irq_ack`  out  1  one-cycle strobe when an interrupt is taken.

## Operation
- FSM states:
  - BOOT: first cycle after reset release.
  - RUN: normal fetch.
  - HOLD: `stall` asserted.
  - BOOT → RUN unconditionally. RUN ↔ HOLD follows `stall`.
- Next-PC sources:
  - PC+4.
  - Branch: `pc_plus4 + branch_off`.
  - Jump: `{pc[31:28], jump_idx, 2'b00}`.
  - jr: `jr_target`. In user mode (`kernel`=0), bit 31 of the target is forced to 0, so user code cannot enter kernel space. In kernel mode, jr may clear PC[31]; this is the only return path.
- Arithmetic is 32-bit wrap-around; there is no overflow detection.
- Priority in RUN: `exc` > interrupt > `pc_src`.
- Exception entry:
  - `pc` ← `EXC_VEC`; `epc` ← `pc_plus4`, so the faulting instruction is skipped.
  - `k0_we`=1.
  - Taken in kernel mode as well.
- Interrupt:
  - `irq_pend` is set on any cycle where `irq`=1.
  - The interrupt is taken when `irq_pend`=1, `kernel`=0, and there is no `exc`.
  - On entry: `pc` ← `IRQ_VEC`; `epc` ← `pc`, so the current instruction is squashed and re-executed on return. `k0_we`=1, `irq_ack`=1, and `irq_pend` is cleared.
  - A request arriving while in kernel mode stays pending until the first user-mode cycle.
- HOLD:
  - `pc`, `epc`, and `irq_pend` hold. `irq` may still set `irq_pend`.
  - `exc` is ignored; the decoder re-asserts it after the stall.
  - `k0_we` and `irq_ack` are 0.

## Timing
- Reset values (async, while `reset`=0):
  - `pc`=`RESET_VEC`, `pc_plus4`=`RESET_VEC`+4, `kernel`=1.
  - `epc`=0, `k0_we`=0, `irq_ack`=0, `irq_pend`=0, state=BOOT.
- BOOT cycle: `pc` holds `RESET_VEC`; no interrupt or exception is taken.
- Next-PC latency: one edge. `pc` updates on the rising edge after the inputs are valid.
- `k0_we`, `irq_ack`, and `epc` are registered and valid in the cycle `pc` equals the vector.
- If `irq` and `exc` are simultaneous: the exception is taken, `irq_pend` remains set, and the interrupt is taken on the first eligible user cycle.
- `stall` falling: the next edge resumes normal selection.
- If `reset` asserts mid-operation, all state returns to reset values immediately, with no waiting for a clock edge.

## Configuration
- `PC_SEQ_BOUNDS_CHECK_EN` defined:
  - Any non-vector next PC whose word index `next[30:2]` ≥ `ROM_WORDS` is redirected to `EXC_VEC`.
  - `epc` ← the offending target; `k0_we`=1.
  - This check has lower priority than `exc` and the interrupt.
- Undefined: targets pass through unchecked, and the ROM's default word handles stray fetches.

## Structure
- Shared package `cpu_pkg`:
  - Vector constants.
  - `pc_src` encoding localparams `PC_SEQ`, `PC_BR`, `PC_J`, `PC_JR`.
  - FSM state encoding.
- One combinational sub-module, `pc_next_mux`: computes the branch/jump/jr/PC+4 candidate and applies the user-mode bit-31 mask.
- The top level owns the registers, the FSM, priority, and bounds logic.

## Test plan
- Reset release: `pc`=8000_0000 for BOOT and one following cycle; `pc_src`=2 with `jump_idx`=3 gives `pc`=8000_000C.
- User-mode jr to 8000_0040 from `pc`=0000_0100: `pc`=0000_0040, `kernel`=0. Kernel-mode jr to 0000_0100 gives `kernel`=0.
- `irq` pulse at user `pc`=0000_0124: next `pc`=8000_0004, `epc`=0000_0124, `k0_we`=`irq_ack`=1 for exactly one cycle. A second `irq` while in kernel mode is taken only after jr returns to user mode.
- `exc` and `irq` simultaneous at `pc`=0000_0050: `pc`=8000_0008, `epc`=0000_0054. The interrupt is taken after return.
- `stall` held 3 cycles with `irq` asserted: `pc` is constant and there is no `irq_ack`. The interrupt is taken on the first cycle after `stall` falls.
- With `PC_SEQ_BOUNDS_CHECK_EN` defined and `ROM_WORDS`=128: jump to 0000_0200 gives `pc`=8000_0008, `epc`=0000_0200. With the macro undefined, `pc`=0000_0200.
